moving_avg_bank: RTL

//   Parametrised multi-channel moving-average low-pass filter for the codec sample path.
//   - Sits between the codec line-in and the headphone output, in the clk_48 domain.
//   - Window is selectable at run time: 2^win_log2 samples, shared by all channels.
//   - Channels are time-multiplexed through one adder, sharing one ring-buffer RAM.
//   - Changing the window flushes the history cleanly.

---
 rtl/audio_filt_pkg.sv | 24 ++
 rtl/moving_avg_bank_if.sv | 37 +++
 rtl/filt_ring_ram.sv | 26 ++
 rtl/moving_avg_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/audio_filt_pkg.sv
// Shared definitions for the codec moving-average filter bank.
// Contents:
//   W_DEF / CH_DEF / MAX_LOG2_DEF  default sample width, channel count and log2 of the
//                                  maximum window (also used by the OLED mode display)
//   state_t                        controller states FLUSH / IDLE / RD / UPD
//   clamp_win()                    limits a requested window select to max_log2
package audio_filt_pkg;

  localparam int W_DEF        = 16;
  localparam int CH_DEF       = 2;
  localparam int MAX_LOG2_DEF = 5;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    RD    = 2'd2,
    UPD   = 2'd3
  } state_t;

  function automatic int unsigned clamp_win(input int unsigned win, input int unsigned max_log2);
    return (win > max_log2) ? max_log2 : win;
  endfunction

endpackage

// File: rtl/moving_avg_bank_if.sv
// Sample-path bundle between the codec line-in side and moving_avg_bank.
// Signals:
//   new_sample  1-cycle strobe, sample_in valid
//   sample_in   CH*W packed samples, channel c at [c*W +: W]
//   win_log2    window select (clamped inside the filter)
//   sample_out  CH*W filtered samples, same packing
//   out_valid   1-cycle pulse when sample_out updates
//   busy        filter is flushing or processing
//   overrun     sticky: a strobe arrived while processing
// Modports: master drives strobes/window, slave is the filter.
interface moving_avg_bank_if
  import audio_filt_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int CH       = CH_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) ();
  localparam int WLW = $clog2(MAX_LOG2 + 1);

  logic              new_sample;
  logic [CH*W-1:0]   sample_in;
  logic [WLW-1:0]    win_log2;
  logic [CH*W-1:0]   sample_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output new_sample, sample_in, win_log2,
    input  sample_out, out_valid, busy, overrun
  );

  modport slave (
    input  new_sample, sample_in, win_log2,
    output sample_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/filt_ring_ram.sv
// Single-port synchronous RAM holding the per-channel sample history rings.
// Read is registered (1-cycle latency) and returns the old contents on a write.
// Ports:
//   clk    clock
//   we     write enable
//   addr   word address
//   wdata  write data
//   rdata  registered read data
module filt_ring_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/moving_avg_bank.sv
// Multi-channel moving-average low-pass filter for the codec sample path (clk_48 domain).
// Window is 2^win shared by all channels; channels are processed one after another
// through a single adder and a shared ring RAM. A window change flushes all history.
// Ports:
//   clk   48 MHz clock
//   rst   synchronous active-high reset
//   bus   moving_avg_bank_if slave (strobe, samples, window, outputs, busy, overrun)
// Build option:
//   AVG_ROUND_EN  when defined, round half up (add 2^(win-1) before the shift, win>0);
//                 otherwise the average is floored.
module moving_avg_bank
  import audio_filt_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int CH       = CH_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic          clk,
  input  logic          rst,
  moving_avg_bank_if.slave bus
);
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int TOT   = CH * DEPTH;
  localparam int AW    = $clog2(TOT);
  localparam int FW    = $clog2(TOT + 1);
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int WLW   = $clog2(MAX_LOG2 + 1);
  localparam int SW    = W + MAX_LOG2;
  localparam int PW    = MAX_LOG2 + 1;

  state_t                 state, state_nxt;
  logic [FW-1:0]          fcnt;
  logic [MAX_LOG2-1:0]    wptr;
  logic [CW-1:0]          ch;
  logic [WLW-1:0]         win_act, win_req;
  logic [CH-1:0][W-1:0]   in_lat, avg_hold, out_q;
  logic [CH-1:0][SW-1:0]  sums;
  logic                   out_valid_q, overrun_q;

  logic                   ram_we;
  logic [AW-1:0]          ram_addr, ch_base;
  logic [W-1:0]           ram_wdata, ram_rdata;

  logic [PW-1:0]          win_pow;
  logic [MAX_LOG2-1:0]    rd_off;
  logic [SW-1:0]          sum_nxt;
  logic signed [SW-1:0]   sum_rnd;
  logic [W-1:0]           avg;
  logic                   last_ch;

  function automatic logic [SW-1:0] sx(input logic [W-1:0] v);
    return {{MAX_LOG2{v[W-1]}}, v};
  endfunction

  assign win_req = WLW'(clamp_win(32'(bus.win_log2), MAX_LOG2));

  // Slot of the sample leaving the window; at the maximum window this is the
  // slot about to be overwritten, so modulo-DEPTH wrap does the right thing.
  assign win_pow = PW'(1) << win_act;
  assign rd_off  = wptr - win_pow[MAX_LOG2-1:0];
  assign ch_base = AW'(ch) << MAX_LOG2;
  assign last_ch = (ch == CW'(CH - 1));

  // ram_rdata holds the departing sample during UPD (read issued in RD).
  assign sum_nxt = sums[ch] + sx(in_lat[ch]) - sx(ram_rdata);

`ifdef AVG_ROUND_EN
  assign sum_rnd = (win_act != '0) ? (sum_nxt + (SW'(1) << (win_act - WLW'(1)))) : sum_nxt;
`else
  assign sum_rnd = sum_nxt;
`endif

  assign avg = W'(sum_rnd >>> win_act);

  assign bus.sample_out = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);

  filt_ring_ram #(.W(W), .DEPTH(TOT), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FLUSH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      FLUSH: begin
        // One extra terminal count cycle after the last RAM word is cleared.
        ram_we   = (fcnt < FW'(TOT));
        ram_addr = fcnt[AW-1:0];
        if (fcnt == FW'(TOT)) state_nxt = IDLE;
      end
      IDLE: begin
        if (win_req != win_act)  state_nxt = FLUSH;
        else if (bus.new_sample) state_nxt = RD;
      end
      RD: begin
        ram_addr  = ch_base + AW'(rd_off);
        state_nxt = UPD;
      end
      UPD: begin
        ram_we    = 1'b1;
        ram_addr  = ch_base + AW'(wptr);
        ram_wdata = in_lat[ch];
        state_nxt = last_ch ? IDLE : RD;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt        <= '0;
      wptr        <= '0;
      ch          <= '0;
      win_act     <= win_req;
      in_lat      <= '0;
      avg_hold    <= '0;
      out_q       <= '0;
      sums        <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          sums <= '0;
          wptr <= '0;
          ch   <= '0;
        end
        IDLE: begin
          fcnt <= '0;
          if (win_req != win_act) win_act <= win_req;
          else if (bus.new_sample) begin
            in_lat <= bus.sample_in;
            ch     <= '0;
          end
        end
        RD: begin
          if (bus.new_sample) overrun_q <= 1'b1;
        end
        UPD: begin
          if (bus.new_sample) overrun_q <= 1'b1;
          sums[ch]     <= sum_nxt;
          avg_hold[ch] <= avg;
          if (last_ch) begin
            wptr        <= wptr + MAX_LOG2'(1);
            out_valid_q <= 1'b1;
            // Present all channels at once; the last one comes straight from the adder.
            for (int c = 0; c < CH; c++)
              out_q[c] <= (CW'(c) == ch) ? avg : avg_hold[c];
          end else begin
            ch <= ch + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
